// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART sender
// with per-message locking and an idle hold timeout.
module uart_tx_arbiter #(
  parameter int N = 3,
  parameter int TW = 16,
  parameter logic [TW-1:0] HOLD_TIMEOUT = 16'd50000
) (
  input  logic           Clk_100M,
  input  logic           Reset,
  input  logic [N-1:0]   Req,
  input  logic [N-1:0]   Req_Last,
  input  logic [8*N-1:0] Req_Data,
  output logic [N-1:0]   Req_Ack,
  output logic [N-1:0]   Grant,
  output logic [7:0]     Tx_Data,
  output logic           Tx_Send,
  input  logic           Tx_Busy,
  output logic           Arb_Busy
);

  localparam int OW = $clog2(N);
  localparam logic [OW-1:0] LAST = OW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [OW-1:0] owner;
  logic [OW-1:0] owner_n;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] rr_ptr_n;
  logic [OW-1:0] pick;
  logic [OW-1:0] sel;
  logic          found;
  logic          last_r;
  logic          last_n;
  logic [TW-1:0] hold_cnt;
  logic [TW-1:0] hold_cnt_n;
  logic [N-1:0]  grant_n;
  logic [N-1:0]  ack_n;
  logic [7:0]    data_n;
  logic          send_n;

  function automatic logic [OW-1:0] inc_ptr(input logic [OW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [OW-1:0] p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // circular search for the first pending request at or after rr_ptr
  always_comb begin
    pick = '0;
    found = 1'b0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel = OW'((int'(rr_ptr) + k) % N);
      if (Req[sel]) begin
        pick = sel;
        found = 1'b1;
      end
    end
  end

  // next state and next values of every registered output
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_ptr_n = rr_ptr;
    last_n = last_r;
    hold_cnt_n = hold_cnt;
    grant_n = Grant;
    data_n = Tx_Data;
    send_n = 1'b0;
    ack_n = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_n = pick;
          grant_n = onehot(pick);
          data_n = Req_Data[{pick, 3'b000} +: 8];
          last_n = Req_Last[pick];
          send_n = 1'b1;
          ack_n = onehot(pick);
          state_n = SEND;
        end
      end
      SEND: state_n = WAIT_START;
      WAIT_START: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (!Tx_Busy) begin
          if (last_r) begin
            grant_n = '0;
            rr_ptr_n = inc_ptr(owner);
            state_n = IDLE;
          end else begin
            hold_cnt_n = '0;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (Req[owner]) begin
          data_n = Req_Data[{owner, 3'b000} +: 8];
          last_n = Req_Last[owner];
          send_n = 1'b1;
          ack_n = onehot(owner);
          state_n = SEND;
        end else if (hold_cnt == HOLD_TIMEOUT - 1'b1) begin
          grant_n = '0;
          rr_ptr_n = inc_ptr(owner);
          state_n = IDLE;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      last_r <= 1'b0;
      hold_cnt <= '0;
      Grant <= '0;
      Tx_Data <= 8'h00;
      Tx_Send <= 1'b0;
      Req_Ack <= '0;
      Arb_Busy <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_ptr_n;
      last_r <= last_n;
      hold_cnt <= hold_cnt_n;
      Grant <= grant_n;
      Tx_Data <= data_n;
      Tx_Send <= send_n;
      Req_Ack <= ack_n;
      Arb_Busy <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: message-level arbitration model plus
// directed timing cases for the shared UART sender.
module tb_uart_tx_arbiter;

  localparam int N = 3;
  localparam int HT = 8;

  typedef struct {
    int cyc;
    int who;
    logic [7:0] data;
    logic [N-1:0] grant;
  } ev_t;

  typedef struct {
    int who;
    logic [7:0] data;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_last;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           arb_busy;

  ev_t        log_q[$];
  exp_t       exp_q[$];
  logic [8:0] rq[N][$];
  logic [8:0] mq[N][$];
  logic [N-1:0] off;
  logic       stuck;
  logic [7:0] prev_data;
  int cyc, errors, checks, frame, bcnt, m_rr, glitch, stray;

  uart_tx_arbiter #(
    .N(N),
    .TW(16),
    .HOLD_TIMEOUT(16'd8)
  ) dut (
    .Clk_100M(clk),
    .Reset(rst_n),
    .Req(req),
    .Req_Last(req_last),
    .Req_Data(req_data),
    .Req_Ack(ack),
    .Grant(grant),
    .Tx_Data(tx_data),
    .Tx_Send(tx_send),
    .Tx_Busy(tx_busy),
    .Arb_Busy(arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] v;
    v = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  // one clock: observe outputs, model sender and requesters
  task automatic step();
    int who;
    @(negedge clk);
    cyc++;
    if (tx_send) begin
      who = -1;
      for (int i = 0; i < N; i++) if (ack[i]) who = i;
      log_q.push_back('{cyc, who, tx_data, grant});
    end else if (ack !== '0) stray++;
    if (rst_n && !tx_send && tx_data !== prev_data) glitch++;
    prev_data = tx_data;
    if (bcnt > 0) bcnt--;
    if (tx_send) bcnt = frame;
    tx_busy = stuck || (bcnt > 0);
    for (int i = 0; i < N; i++)
      if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !off[i]) begin
        req[i] = 1'b1;
        req_last[i] = rq[i][0][8];
        req_data[i*8 +: 8] = rq[i][0][7:0];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic run_idle(input int maxc, output bit ok);
    bit pend;
    ok = 1'b0;
    for (int n = 0; n < maxc && !ok; n++) begin
      step();
      pend = 1'b0;
      for (int i = 0; i < N; i++)
        if (rq[i].size() > 0 && !off[i]) pend = 1'b1;
      if (!pend && !arb_busy && !tx_busy && n > 0) ok = 1'b1;
    end
  endtask

  // whole messages go out in round-robin order of requesters
  task automatic build_expect();
    int f;
    int idx;
    logic [8:0] b;
    exp_q.delete();
    for (int k = 0; k < N; k++) mq[k] = rq[k];
    f = 0;
    while (f >= 0) begin
      f = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (f < 0 && mq[idx].size() > 0) f = idx;
      end
      if (f >= 0) begin
        b = 9'h000;
        while (!b[8] && mq[f].size() > 0) begin
          b = mq[f].pop_front();
          exp_q.push_back('{f, b[7:0]});
        end
        m_rr = (f + 1) % N;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (grant !== '0) begin
      errors++; $display("FAIL reset_grant got=%b want=000", grant);
    end
    checks++;
    if (ack !== '0) begin
      errors++; $display("FAIL reset_ack got=%b want=000", ack);
    end
    checks++;
    if (tx_send !== 1'b0) begin
      errors++; $display("FAIL reset_send got=%b want=0", tx_send);
    end
    checks++;
    if (tx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data got=%h want=00", tx_data);
    end
    checks++;
    if (arb_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b want=0", arb_busy);
    end
    rst_n = 1'b1;
    m_rr = 0;
    step();
  endtask

  task automatic test_single_byte();
    int c;
    bit ok;
    frame = $urandom_range(2, 6);
    log_q.delete();
    rq[1].push_back({1'b1, 8'h41});
    build_expect();
    step();
    c = cyc;
    run_idle(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_idle got=timeout want=idle");
    end
    checks++;
    if (log_q.size() !== 1) begin
      errors++; $display("FAIL single_count got=%0d want=1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].cyc !== c + 1) begin
        errors++;
        $display("FAIL single_latency got=%0d want=%0d", log_q[0].cyc - c, 1);
      end
      checks++;
      if (log_q[0].who !== 1 || log_q[0].data !== 8'h41 || log_q[0].grant !== 3'b010) begin
        errors++;
        $display("FAIL single_byte got=%0d/%h/%b want=1/41/010",
                 log_q[0].who, log_q[0].data, log_q[0].grant);
      end
    end
    checks++;
    if (grant !== '0) begin
      errors++; $display("FAIL single_release got=%b want=000", grant);
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    frame = $urandom_range(2, 6);
    log_q.delete();
    rq[2].push_back({1'b1, 8'h5A});
    stuck = 1'b1;
    for (int n = 0; n < 20 && log_q.size() == 0; n++) step();
    repeat (4) step();
    checks++;
    if (grant !== 3'b100 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL midrst_owned got=%b/%b want=100/1", grant, arb_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || tx_send !== 1'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got=%b/%b/%b want=000/0/0", grant, tx_send, arb_busy);
    end
    stuck = 1'b0;
    repeat (2) step();
    log_q.delete();
    rq[1].push_back({1'b1, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    m_rr = 0;
    build_expect();
    rst_n = 1'b1;
    run_idle(300, ok);
    checks++;
    if (!ok || log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count got=%0d want=%0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].who !== exp_q[k].who || log_q[k].data !== exp_q[k].data ||
          log_q[k].grant !== oh(exp_q[k].who)) begin
        errors++;
        $display("FAIL midrst_order[%0d] got=%0d/%h want=%0d/%h", k,
                 log_q[k].who, log_q[k].data, exp_q[k].who, exp_q[k].data);
      end
    end
  endtask

  task automatic test_locked_message();
    bit ok;
    frame = $urandom_range(2, 6);
    log_q.delete();
    rq[0].push_back({1'b0, 8'h4F});
    rq[0].push_back({1'b0, 8'h4B});
    rq[0].push_back({1'b1, 8'h0D});
    rq[2].push_back({1'b1, 8'($urandom)});
    build_expect();
    run_idle(500, ok);
    checks++;
    if (!ok || log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL locked_count got=%0d want=%0d", log_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].who !== exp_q[k].who || log_q[k].data !== exp_q[k].data ||
          log_q[k].grant !== oh(exp_q[k].who)) begin
        errors++;
        $display("FAIL locked_order[%0d] got=%0d/%h want=%0d/%h", k,
                 log_q[k].who, log_q[k].data, exp_q[k].who, exp_q[k].data);
      end
      if (k > 0) begin
        checks++;
        if (log_q[k].cyc - log_q[k-1].cyc !== frame + 2) begin
          errors++;
          $display("FAIL locked_gap[%0d] got=%0d want=%0d", k,
                   log_q[k].cyc - log_q[k-1].cyc, frame + 2);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    frame = $urandom_range(2, 6);
    log_q.delete();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'($urandom)});
    build_expect();
    run_idle(500, ok);
    checks++;
    if (!ok || log_q.size() !== 6) begin
      errors++; $display("FAIL rr_count got=%0d want=6", log_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
      checks++;
      if (log_q[k].who !== k % N || log_q[k].data !== exp_q[k].data) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d/%h want=%0d/%h", k,
                 log_q[k].who, log_q[k].data, k % N, exp_q[k].data);
      end
      if (k > 0) begin
        checks++;
        if (log_q[k].cyc - log_q[k-1].cyc !== frame + 2) begin
          errors++;
          $display("FAIL rr_gap[%0d] got=%0d want=%0d", k,
                   log_q[k].cyc - log_q[k-1].cyc, frame + 2);
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    bit ok;
    int nm;
    int len;
    for (int it = 0; it < 5; it++) begin
      frame = $urandom_range(2, 6);
      log_q.delete();
      for (int i = 0; i < N; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            rq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      build_expect();
      run_idle(1500, ok);
      checks++;
      if (!ok || log_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got=%0d want=%0d", it, log_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
        checks++;
        if (log_q[k].who !== exp_q[k].who || log_q[k].data !== exp_q[k].data ||
            log_q[k].grant !== oh(exp_q[k].who)) begin
          errors++;
          $display("FAIL rand%0d_order[%0d] got=%0d/%h want=%0d/%h", it, k,
                   log_q[k].who, log_q[k].data, exp_q[k].who, exp_q[k].data);
        end
        if (k > 0) begin
          checks++;
          if (log_q[k].cyc - log_q[k-1].cyc !== frame + 2) begin
            errors++;
            $display("FAIL rand%0d_gap[%0d] got=%0d want=%0d", it, k,
                     log_q[k].cyc - log_q[k-1].cyc, frame + 2);
          end
        end
      end
    end
  endtask

  task automatic test_hold_timeout();
    int s;
    int hold_in;
    bit ok;
    frame = $urandom_range(2, 6);
    log_q.delete();
    rq[1].push_back({1'b0, 8'h31});
    for (int n = 0; n < 20 && log_q.size() == 0; n++) step();
    checks++;
    if (log_q.size() !== 1 || log_q[0].who !== 1) begin
      errors++; $display("FAIL hold_first got=%0d want=1", log_q.size());
    end
    s = (log_q.size() > 0) ? log_q[0].cyc : cyc;
    hold_in = s + frame + 1;
    rq[2].push_back({1'b1, 8'hA5});
    while (cyc < hold_in + HT) begin
      step();
      if (cyc == hold_in + HT - 1) begin
        checks++;
        if (grant !== 3'b010 || arb_busy !== 1'b1) begin
          errors++;
          $display("FAIL hold_kept got=%b/%b want=010/1", grant, arb_busy);
        end
      end
      if (cyc == hold_in + HT) begin
        checks++;
        if (grant !== '0 || arb_busy !== 1'b0) begin
          errors++;
          $display("FAIL hold_release got=%b/%b want=000/0", grant, arb_busy);
        end
      end
    end
    run_idle(200, ok);
    checks++;
    if (!ok || log_q.size() !== 2) begin
      errors++; $display("FAIL hold_count got=%0d want=2", log_q.size());
    end else begin
      checks++;
      if (log_q[1].who !== 2 || log_q[1].data !== 8'hA5 || log_q[1].cyc !== hold_in + HT + 1) begin
        errors++;
        $display("FAIL hold_next got=%0d/%h/+%0d want=2/a5/+%0d",
                 log_q[1].who, log_q[1].data, log_q[1].cyc - s, hold_in + HT + 1 - s);
      end
    end
    m_rr = 0;
  endtask

  task automatic test_wrap_withdraw();
    bit ok;
    int c;
    frame = $urandom_range(2, 6);
    rq[1].push_back({1'b1, 8'h61});
    build_expect();
    run_idle(200, ok);
    log_q.delete();
    rq[0].push_back({1'b1, 8'h30});
    build_expect();
    step();
    c = cyc;
    run_idle(200, ok);
    checks++;
    if (!ok || log_q.size() !== 1) begin
      errors++; $display("FAIL wrap_count got=%0d want=1", log_q.size());
    end else begin
      checks++;
      if (log_q[0].who !== 0 || log_q[0].data !== 8'h30 || log_q[0].cyc !== c + 1) begin
        errors++;
        $display("FAIL wrap_grant got=%0d/%h/+%0d want=0/30/+1",
                 log_q[0].who, log_q[0].data, log_q[0].cyc - c);
      end
    end
    frame = 8;
    log_q.delete();
    rq[0].push_back({1'b1, 8'h77});
    for (int n = 0; n < 20 && log_q.size() == 0; n++) step();
    rq[2].push_back({1'b1, 8'hEE});
    repeat (3) step();
    rq[2].delete();
    run_idle(200, ok);
    repeat (3) step();
    checks++;
    if (!ok || log_q.size() !== 1) begin
      errors++; $display("FAIL withdraw_count got=%0d want=1", log_q.size());
    end
    checks++;
    if (grant !== '0 || arb_busy !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL withdraw_idle got=%b/%b/%b want=000/0/000", grant, arb_busy, ack);
    end
  endtask

  task automatic test_data_stable();
    checks++;
    if (glitch !== 0) begin
      errors++; $display("FAIL data_stable got=%0d want=0", glitch);
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL stray_ack got=%0d want=0", stray);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    req_last = '0;
    req_data = '0;
    tx_busy = 1'b0;
    off = '0;
    stuck = 1'b0;
    prev_data = 8'h00;
    cyc = 0;
    errors = 0;
    checks = 0;
    bcnt = 0;
    glitch = 0;
    stray = 0;
    m_rr = 0;
    frame = 4;
    test_reset();
    test_single_byte();
    test_reset_midframe();
    test_locked_message();
    test_round_robin();
    test_random_traffic();
    test_hold_timeout();
    test_wrap_withdraw();
    test_data_stable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
